// File: rtl/data_ram.sv
// Multi-port read, byte-enable write RAM; optional read-during-write bypass via DATA_RAM_BYPASS_EN.
// One-cycle registered reads; no backpressure, every request is accepted each cycle.
module data_ram #(
  parameter int Width      = 32,
  parameter int Depth      = 32,
  parameter int AddrWidth  = 30,
  parameter int NumRdPorts = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NumRdPorts-1:0]                rd_en,
  input  logic [NumRdPorts-1:0][AddrWidth-1:0] rd_addr,
  output logic [NumRdPorts-1:0][Width-1:0]     rd_data,
  output logic [NumRdPorts-1:0]                rd_valid,
  output logic [NumRdPorts-1:0]                rd_err,
  input  logic                                 wr_en,
  input  logic [AddrWidth-1:0]                 wr_addr,
  input  logic [Width-1:0]                     wr_data,
  input  logic [Width/8-1:0]                   wr_be,
  output logic                                 wr_err
);

  localparam int NumBytes = Width / 8;
  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
  // One extra bit so Depth == 2**AddrWidth still compares correctly.
  localparam logic [AddrWidth:0] DepthExt = (AddrWidth + 1)'(Depth);

  logic [Width-1:0] mem [0:Depth-1];

  logic                                wr_in_range;
  logic                                wr_hit;
  logic [IdxWidth-1:0]                 wr_idx;
  logic [Width-1:0]                    wr_mask;
  logic [NumRdPorts-1:0]               rd_in_range;
  logic [NumRdPorts-1:0][IdxWidth-1:0] rd_idx;
  logic [NumRdPorts-1:0][Width-1:0]    rd_word;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DepthExt);
    wr_idx      = wr_addr[IdxWidth-1:0];
    wr_mask     = '0;
    for (int b = 0; b < NumBytes; b++) begin
      wr_mask[8*b +: 8] = {8{wr_be[b]}};
    end
    // A write with no byte enables is treated as no write at all.
    wr_hit = reset & wr_en & wr_in_range & (|wr_be);
  end

  always_comb begin
    rd_in_range = '0;
    rd_idx      = '0;
    rd_word     = '0;
    for (int i = 0; i < NumRdPorts; i++) begin
      rd_in_range[i] = ({1'b0, rd_addr[i]} < DepthExt);
      rd_idx[i]      = rd_addr[i][IdxWidth-1:0];
      if (rd_in_range[i]) begin
        rd_word[i] = mem[rd_idx[i]];
      end
`ifdef DATA_RAM_BYPASS_EN
      if (wr_hit && (rd_addr[i] == wr_addr)) begin
        rd_word[i] = (rd_word[i] & ~wr_mask) | (wr_data & wr_mask);
      end
`endif
    end
  end

  // Storage is deliberately not reset so it can be preloaded.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= '0;
      rd_err   <= '0;
      wr_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NumRdPorts; i++) begin
        rd_valid[i] <= rd_en[i];
        rd_err[i]   <= rd_en[i] & ~rd_in_range[i];
        if (rd_en[i]) begin
          rd_data[i] <= rd_word[i];
        end
      end
      wr_err <= wr_en & ~wr_in_range & (|wr_be);
    end
  end

endmodule
